key_debounce_sync: RTL and testbench
====================================

Name: key_debounce_sync

Overview:
- Input-side conditioner for the board push-buttons.
- Takes raw, asynchronous, bouncing active-low key lines and synchronizes them into the CLK domain.
- Debounces each key independently.
- Delivers a clean level plus one-cycle press and release pulses to downstream trigger/LED logic, so that logic never samples raw keys directly.

Parameters:
- N_KEYS, 4: number of independent key channels.
- DEBOUNCE_W, 20: width of each per-key stability counter. A level must be held 2^DEBOUNCE_W cycles after synchronization before it is accepted.
- KEY_ACTIVE_LOW, 1: 1 means raw 0 is pressed; 0 means raw 1 is pressed.
- REPEAT_W, 24: auto-repeat interval exponent. Used only when KEYREP_AUTOREPEAT_EN is defined.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- KEY_SW  input  N_KEYS  raw asynchronous key lines.
- key_state  output  N_KEYS  debounced level; 1 means pressed.
- key_press  output  N_KEYS  one-cycle pulse on an accepted press (and on auto-repeat, if enabled).
- key_release  output  N_KEYS  one-cycle pulse on an accepted release.

Behaviour:
- Synchronizer: two-flop chain per key (sync1 then sync2), followed by polarity normalization so that pressed = 1 internally.
- Reset (RESET=0 at a rising edge):
  - sync1 and sync2 load the released raw level (all ones if KEY_ACTIVE_LOW=1).
  - key_state, key_press, key_release, all counters and all repeat counters clear to 0.
  - No press or release pulse may result from reset entry or exit.
- Per-key 2-state FSM: RELEASED (key_state=0) and PRESSED (key_state=1). The stability counter is DEBOUNCE_W bits wide, with MAX = 2^DEBOUNCE_W-1.
- Counter rules, each rising edge, per key:
  - If sync2 equals key_state: counter clears to 0. Any bounce back before acceptance discards progress.
  - If sync2 differs and counter < MAX: counter increments by 1.
  - If sync2 differs and counter == MAX: key_state toggles, counter clears, and exactly one pulse fires.
    - key_press=1 for one cycle on a RELEASED->PRESSED transition.
    - key_release=1 for one cycle on a PRESSED->RELEASED transition.
- Latency: a new raw level first captured by sync1 at edge k and held constant updates key_state at edge k+2^DEBOUNCE_W+1. The pulse is high during the cycle after that edge. Pulse and key_state change on the same edge.
- Counter never wraps: MAX with sync2 differing always forces acceptance.
- Pulses are registered outputs, default 0, and never last more than one cycle. key_press and key_release are never both 1 for the same key.
- Keys are fully independent. Simultaneous accepted transitions on several keys assert their pulse bits in the same cycle.

Optional Feature:
- Macro: KEYREP_AUTOREPEAT_EN.
- When defined:
  - Each key has a REPEAT_W-bit repeat counter, cleared on every accepted press and held at 0 while RELEASED.
  - While PRESSED, the repeat counter increments every cycle.
  - When it reaches 2^REPEAT_W-1, the next edge asserts key_press for one cycle and clears the repeat counter. Repeat pulses therefore recur every 2^REPEAT_W cycles while held.
  - An accepted release clears the repeat counter; the release pulse is unaffected.
- When undefined: exactly one key_press per accepted press, with no repeat logic synthesized.

Test Plan (DEBOUNCE_W=2, KEY_ACTIVE_LOW=1, N_KEYS=4):
- Reset: RESET=0 for 3 cycles with KEY_SW=4'hF, then RESET=1 for 20 cycles -> key_state=0; key_press and key_release stay 4'b0000 throughout.
- Clean press/release:
  - KEY_SW=4'hE first sampled at edge k -> key_state=4'b0001 after edge k+5; key_press=4'b0001 for exactly one cycle.
  - KEY_SW=4'hF sampled at edge j -> key_state=0 after edge j+5; key_release=4'b0001 for one cycle.
- Bounce: KEY_SW[1] toggles every 2 cycles for 20 cycles, then is held 0 -> no pulses during the toggling; single key_press=4'b0010 exactly 5 edges after the final level is first sampled.
- Simultaneous: KEY_SW=4'h3 applied at one edge -> key_press=4'b1100 in a single cycle; key_state=4'b1100.
- Reset mid-operation:
  - With key0 held low, assert RESET while key0's counter=2 -> key_state, counters and pulses all 0.
  - After RESET=1 with the key still low -> exactly one press pulse, 2^2+1 edges after sync1 first recaptures 0.
- Auto-repeat (KEYREP_AUTOREPEAT_EN, REPEAT_W=3) -> hold key3 for 40 cycles: initial key_press[3], then a repeat pulse every 8 cycles; no repeat pulses after release.

Source files
------------

// File: rtl/key_debounce_sync.sv
// Two-flop synchronizer plus per-key debounce FSM with registered press/release pulses.
// Optional auto-repeat of key_press while held is enabled by defining KEYREP_AUTOREPEAT_EN.
module key_debounce_sync #(
    parameter int N_KEYS         = 4,
    parameter int DEBOUNCE_W     = 20,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int REPEAT_W       = 24
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY_SW,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam logic [N_KEYS-1:0]     RAW_RELEASED = (KEY_ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};
    localparam logic [DEBOUNCE_W-1:0] CNT_MAX      = {DEBOUNCE_W{1'b1}};
    localparam logic [DEBOUNCE_W-1:0] CNT_ZERO     = {DEBOUNCE_W{1'b0}};
    localparam logic [DEBOUNCE_W-1:0] CNT_ONE      = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};
`ifdef KEYREP_AUTOREPEAT_EN
    localparam logic [REPEAT_W-1:0]   REP_MAX      = {REPEAT_W{1'b1}};
    localparam logic [REPEAT_W-1:0]   REP_ZERO     = {REPEAT_W{1'b0}};
    localparam logic [REPEAT_W-1:0]   REP_ONE      = {{(REPEAT_W-1){1'b0}}, 1'b1};
`endif

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } key_st_e;

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] w_level;

    // Two-flop synchronizer; reset loads the released raw level so reset exit looks idle.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_sync1 <= RAW_RELEASED;
            r_sync2 <= RAW_RELEASED;
        end else begin
            r_sync1 <= KEY_SW;
            r_sync2 <= r_sync1;
        end
    end

    // Polarity normalization: pressed is 1 internally regardless of board wiring.
    always_comb begin
        w_level = {N_KEYS{1'b0}};
        if (KEY_ACTIVE_LOW != 0) begin
            w_level = ~r_sync2;
        end else begin
            w_level = r_sync2;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_st_e               r_state;
        logic [DEBOUNCE_W-1:0] r_cnt;
        logic                  r_press;
        logic                  r_release;
`ifdef KEYREP_AUTOREPEAT_EN
        logic [REPEAT_W-1:0]   r_rep;
`endif

        // Debounce FSM: a differing level must persist through a full counter span to be accepted.
        always_ff @(posedge CLK) begin
            if (!RESET) begin
                r_state   <= ST_RELEASED;
                r_cnt     <= CNT_ZERO;
                r_press   <= 1'b0;
                r_release <= 1'b0;
`ifdef KEYREP_AUTOREPEAT_EN
                r_rep     <= REP_ZERO;
`endif
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (r_state)
                    ST_RELEASED: begin
`ifdef KEYREP_AUTOREPEAT_EN
                        r_rep <= REP_ZERO;
`endif
                        if (w_level[g]) begin
                            if (r_cnt == CNT_MAX) begin
                                r_state <= ST_PRESSED;
                                r_cnt   <= CNT_ZERO;
                                r_press <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                        end else begin
                            r_cnt <= CNT_ZERO;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_level[g] && (r_cnt == CNT_MAX)) begin
                            r_state   <= ST_RELEASED;
                            r_cnt     <= CNT_ZERO;
                            r_release <= 1'b1;
`ifdef KEYREP_AUTOREPEAT_EN
                            r_rep     <= REP_ZERO;
`endif
                        end else begin
                            if (!w_level[g]) begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end else begin
                                r_cnt <= CNT_ZERO;
                            end
`ifdef KEYREP_AUTOREPEAT_EN
                            // Release acceptance wins over a coinciding repeat so pulses never overlap.
                            if (r_rep == REP_MAX) begin
                                r_rep   <= REP_ZERO;
                                r_press <= 1'b1;
                            end else begin
                                r_rep <= r_rep + REP_ONE;
                            end
`endif
                        end
                    end
                    default: begin
                        r_state <= ST_RELEASED;
                        r_cnt   <= CNT_ZERO;
`ifdef KEYREP_AUTOREPEAT_EN
                        r_rep   <= REP_ZERO;
`endif
                    end
                endcase
            end
        end

        assign key_state[g]   = (r_state == ST_PRESSED);
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;
    end

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync with DEBOUNCE_W=2 (acceptance 5 edges after first sample).
// Auto-repeat checks are compiled only when KEYREP_AUTOREPEAT_EN is defined.
module tb_key_debounce_sync;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] sw;
        logic [3:0] exp_state;
        logic [3:0] exp_press;
        logic [3:0] exp_release;
    } vec_t;

    vec_t vecs[$];

    key_debounce_sync #(
        .N_KEYS(4),
        .DEBOUNCE_W(2),
        .KEY_ACTIVE_LOW(1),
        .REPEAT_W(3)
    ) dut (
        .CLK(clk),
        .RESET(rst_n),
        .KEY_SW(sw),
        .key_state(key_state),
        .key_press(key_press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive inputs, let one rising edge sample them, then check outputs 1 time unit later.
    task automatic step(input string name, input int idx, input logic r, input logic [3:0] s,
                        input logic [3:0] es, input logic [3:0] ep, input logic [3:0] er);
        rst_n = r;
        sw    = s;
        @(posedge clk);
        #1;
        check({name, ".state"},   idx, key_state,   es);
        check({name, ".press"},   idx, key_press,   ep);
        check({name, ".release"}, idx, key_release, er);
    endtask

    task automatic add(input logic r, input logic [3:0] s, input logic [3:0] es,
                       input logic [3:0] ep, input logic [3:0] er, input int n);
        vec_t v;
        v.rst_n = r; v.sw = s; v.exp_state = es; v.exp_press = ep; v.exp_release = er;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        sw    = 4'hF;
        #2;

        // Reset then idle
        add(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 3);
        add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 20);
        // Glitch held one edge short of acceptance
        add(1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 3);
        add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 8);
        // Clean press of key0
        add(1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 5);
        add(1'b1, 4'hE, 4'h1, 4'h1, 4'h0, 1);
        add(1'b1, 4'hE, 4'h1, 4'h0, 4'h0, 2);
        // Clean release of key0
        add(1'b1, 4'hF, 4'h1, 4'h0, 4'h0, 5);
        add(1'b1, 4'hF, 4'h0, 4'h0, 4'h1, 1);
        add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 2);
        // Simultaneous press and release of keys 2 and 3
        add(1'b1, 4'h3, 4'h0, 4'h0, 4'h0, 5);
        add(1'b1, 4'h3, 4'hC, 4'hC, 4'h0, 1);
        add(1'b1, 4'h3, 4'hC, 4'h0, 4'h0, 2);
        add(1'b1, 4'hF, 4'hC, 4'h0, 4'h0, 5);
        add(1'b1, 4'hF, 4'h0, 4'h0, 4'hC, 1);
        add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            step("vec", i, vecs[i].rst_n, vecs[i].sw, vecs[i].exp_state,
                 vecs[i].exp_press, vecs[i].exp_release);
        end

        // Bounce on key1: 2-cycle phases never reach acceptance
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 2; c++) begin
                step("bounce", p * 2 + c, 1'b1, (p % 2 == 0) ? 4'hD : 4'hF, 4'h0, 4'h0, 4'h0);
            end
        end
        for (int t = 0; t < 5; t++) step("bounce_hold", t, 1'b1, 4'hD, 4'h0, 4'h0, 4'h0);
        step("bounce_hold", 5, 1'b1, 4'hD, 4'h2, 4'h2, 4'h0);
        step("bounce_hold", 6, 1'b1, 4'hD, 4'h2, 4'h0, 4'h0);
        for (int t = 0; t < 5; t++) step("bounce_rel", t, 1'b1, 4'hF, 4'h2, 4'h0, 4'h0);
        step("bounce_rel", 5, 1'b1, 4'hF, 4'h0, 4'h0, 4'h2);
        step("bounce_rel", 6, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);

        // Reset while key0's counter is 2, then re-acceptance after reset exit
        for (int t = 0; t < 4; t++) step("rst_mid", t, 1'b1, 4'hE, 4'h0, 4'h0, 4'h0);
        step("rst_mid_rst", 0, 1'b0, 4'hE, 4'h0, 4'h0, 4'h0);
        for (int t = 0; t < 5; t++) step("rst_mid_exit", t, 1'b1, 4'hE, 4'h0, 4'h0, 4'h0);
        step("rst_mid_exit", 5, 1'b1, 4'hE, 4'h1, 4'h1, 4'h0);
        step("rst_mid_exit", 6, 1'b1, 4'hE, 4'h1, 4'h0, 4'h0);
        // Reset while pressed gives no release pulse; key is re-accepted afterwards
        step("rst_pressed", 0, 1'b0, 4'hE, 4'h0, 4'h0, 4'h0);
        for (int t = 0; t < 5; t++) step("rst_pr_exit", t, 1'b1, 4'hE, 4'h0, 4'h0, 4'h0);
        step("rst_pr_exit", 5, 1'b1, 4'hE, 4'h1, 4'h1, 4'h0);
        for (int t = 0; t < 5; t++) step("rst_pr_rel", t, 1'b1, 4'hF, 4'h1, 4'h0, 4'h0);
        step("rst_pr_rel", 5, 1'b1, 4'hF, 4'h0, 4'h0, 4'h1);
        step("rst_pr_rel", 6, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);

`ifdef KEYREP_AUTOREPEAT_EN
        // Hold key3 for 40 edges: press at t=5, repeats every 8 edges, none after release
        for (int t = 0; t < 52; t++) begin
            logic [3:0] es;
            logic [3:0] ep;
            logic [3:0] er;
            es = (t >= 5 && t < 45) ? 4'h8 : 4'h0;
            ep = (t >= 5 && t < 45 && ((t - 5) % 8 == 0)) ? 4'h8 : 4'h0;
            er = (t == 45) ? 4'h8 : 4'h0;
            step("autorep", t, 1'b1, (t < 40) ? 4'h7 : 4'hF, es, ep, er);
        end
`endif

        k = n_tests;
        $display("[TB] %0d tests run, %0d failed", k, n_fail);
        $finish;
    end

endmodule
